// File: rtl/ccm_pkg.sv
// Shared constants and FSM encoding for the line-delay controller around register_array.
package ccm_pkg;

  localparam int BIT_WIDTH    = 8;
  localparam int BUF_WIDTH    = 9;
  localparam int BUF_SIZE     = 257;
  localparam int SCRATCH_SLOT = 256;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_STREAM = 2'd2
  } state_t;

endpackage

// File: rtl/reg_array_ctrl.sv
// One-line delay controller: pairs each pixel with the pixel ROW_LEN accepts earlier.
// Optional top-row zero padding is enabled by defining RA_CTRL_ZERO_PAD_EN.
//
// state     | meaning
// ST_IDLE   | no pixel of the current line stored yet
// ST_FILL   | first line being written, no vertical neighbour available
// ST_STREAM | full line stored, every accept yields a (cur, prev) pair
module reg_array_ctrl #(
  parameter int BIT_WIDTH = ccm_pkg::BIT_WIDTH,
  parameter int BUF_WIDTH = ccm_pkg::BUF_WIDTH,
  parameter int ROW_LEN   = 256
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 frame_start,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BIT_WIDTH-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BIT_WIDTH-1:0] out_cur,
  output logic [BIT_WIDTH-1:0] out_prev,
  output logic [BUF_WIDTH-1:0] ra_wr_ptr,
  output logic [BUF_WIDTH-1:0] ra_rd_ptr,
  output logic [BIT_WIDTH-1:0] ra_data_in,
  input  logic [BIT_WIDTH-1:0] ra_data_out
);
  import ccm_pkg::*;

  localparam logic [BUF_WIDTH-1:0] LAST_SLOT = BUF_WIDTH'(ROW_LEN - 1);
  localparam logic [BUF_WIDTH-1:0] SCRATCH   = BUF_WIDTH'(SCRATCH_SLOT);

  state_t               state, state_nxt, eff_state;
  logic [BUF_WIDTH-1:0] wp, wp_nxt, slot;
  logic                 accept, emit, last_slot;
  logic [BIT_WIDTH-1:0] prev_nxt;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready && rst_n;

  // frame_start takes effect before a coincident accept, so that accept lands in slot 0.
  always_comb begin
    eff_state = frame_start ? ST_IDLE : state;
    slot      = frame_start ? '0 : wp;
    last_slot = (slot == LAST_SLOT);
    state_nxt = eff_state;
    wp_nxt    = slot;
    if (accept) begin
      wp_nxt = last_slot ? '0 : slot + 1'b1;
      case (eff_state)
        ST_IDLE, ST_FILL: state_nxt = last_slot ? ST_STREAM : ST_FILL;
        default:          state_nxt = ST_STREAM;
      endcase
    end
  end

  always_comb begin
`ifdef RA_CTRL_ZERO_PAD_EN
    emit = accept;
`else
    emit = accept && (eff_state == ST_STREAM);
`endif
    prev_nxt   = (eff_state == ST_STREAM) ? ra_data_out : '0;
    ra_wr_ptr  = accept ? slot : SCRATCH;
    ra_rd_ptr  = slot;
    ra_data_in = accept ? in_data : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      wp    <= '0;
    end else begin
      state <= state_nxt;
      wp    <= wp_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_cur   <= '0;
      out_prev  <= '0;
    end else if (emit) begin
      out_valid <= 1'b1;
      out_cur   <= in_data;
      out_prev  <= prev_nxt;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/reg_array_ctrl.md
REG_ARRAY_CTRL -- requirements
Module: reg_array_ctrl

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 8, pixel width.
REQ-002 SHALL have parameter BUF_WIDTH, default 9, pointer width.
REQ-003 SHALL have parameter ROW_LEN, default 256, line delay in pixels; legal range 2..256.
REQ-004 SHALL have port clk, input, 1, sole clock; all state updates on posedge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port frame_start, input, 1, single-cycle pulse that restarts the line fill.
REQ-007 SHALL have ports in_valid (input, 1), in_ready (output, 1) and in_data (input, BIT_WIDTH) as the upstream pixel stream.
REQ-008 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_cur (output, BIT_WIDTH, current pixel) and out_prev (output, BIT_WIDTH, pixel ROW_LEN accepts earlier).
REQ-009 SHALL have ports ra_wr_ptr (output, BUF_WIDTH), ra_rd_ptr (output, BUF_WIDTH), ra_data_in (output, BIT_WIDTH) and ra_data_out (input, BIT_WIDTH), which drive the 257-entry register_array.

Function
REQ-010 SHALL treat the array as writing ra_data_in at ra_wr_ptr on every posedge, with a combinational read of ra_rd_ptr, so a read of a slot returns its old value in the cycle that slot is written.
REQ-011 SHALL use slots 0..ROW_LEN-1 for data and park ra_wr_ptr at scratch slot 256 in every cycle without an accept.
REQ-012 SHALL define accept as in_valid && in_ready, with in_ready = !out_valid || out_ready.
REQ-013 SHALL, on accept, drive ra_wr_ptr = ra_rd_ptr = wp and ra_data_in = in_data, and advance wp by 1, wrapping from ROW_LEN-1 to 0.
REQ-014 SHALL implement FSM IDLE -> FILL on first accept; FILL -> STREAM on the accept that writes slot ROW_LEN-1; STREAM stays in STREAM; any state -> IDLE on frame_start.
REQ-015 SHALL, in STREAM, register out_cur = in_data and out_prev = ra_data_out on accept, and set out_valid the next cycle (latency 1).
REQ-016 SHALL hold out_valid/out_cur/out_prev stable while out_valid && !out_ready, and clear out_valid on out_ready with no new accept.
REQ-017 SHALL, when frame_start and accept occur in the same cycle, apply frame_start first: write slot 0, set wp = 1, next state FILL.
REQ-018 SHALL, on frame_start, leave a pending output word intact (it is still delivered).
REQ-019 SHALL, with ROW_LEN = 2, alternate slots 0 and 1 and enter STREAM after the second accept.

Reset
REQ-020 SHALL, on rst_n low, asynchronously set state IDLE, wp 0, out_valid 0, out_cur 0, out_prev 0, ra_wr_ptr 256, ra_rd_ptr 0 and ra_data_in 0.
REQ-021 SHALL, when reset is asserted mid-line, discard all fill progress; array contents are don't-care after reset.

Configuration
REQ-022 SHALL support macro RA_CTRL_ZERO_PAD_EN: when defined, accepts in FILL also produce output words with out_prev = 0 (top-row zero padding); when undefined, FILL accepts produce no output.

Structure
REQ-023 SHALL place BIT_WIDTH, BUF_WIDTH, BUF_SIZE = 257, SCRATCH_SLOT = 256 and the FSM state encoding in a shared package ccm_pkg.
REQ-024 SHALL contain no sub-module; register_array is instantiated beside it by the parent.

Verification
REQ-025 SHALL check the reset value: rst_n low at t=0 -> ra_wr_ptr = 256, out_valid = 0 and in_ready = 1.
REQ-026 SHALL check line delay: ROW_LEN = 256, stream pixels 0..511 continuously -> first out_valid carries out_cur = 0x00 (pixel 256 mod 256) with out_prev = 0, and every subsequent pair satisfies out_cur == out_prev (8-bit wrap).
REQ-027 SHALL check backpressure: hold out_ready = 0 for 5 cycles in STREAM -> in_ready = 0, outputs frozen, no ra_wr_ptr other than 256, and no data lost after release.
REQ-028 SHALL check restart: frame_start coincident with accept of value 0xAA -> slot 0 = 0xAA, wp = 1, state FILL, and no output until ROW_LEN accepts.
REQ-029 SHALL check padding: with RA_CTRL_ZERO_PAD_EN defined and ROW_LEN = 4, send 1,2,3,4,5 -> outputs (1,0),(2,0),(3,0),(4,0),(5,1).
REQ-030 SHALL check wrap: ROW_LEN = 3, send 9 pixels -> ra_wr_ptr sequence 0,1,2,0,1,2,0,1,2 on accept cycles.
